// File: rtl/glb_axi_wr_packer.sv
// -----------------------------------------------------------------------------
// glb_axi_wr_packer
//
// Packs the 32-bit host AXI write stream into 64-bit GLB bank words with byte
// strobes. The packer also splits the flat GLB byte address into a tile index
// and a tile-local bank address. Each finished bank word is presented through
// a one-entry registered valid/ready request toward the GLB tile write port.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   in_start     loads the base byte address (honoured only while idle)
//   in_addr      base byte address, sampled together with in_start
//   in_valid     host word valid
//   in_ready     host word accepted on in_valid && in_ready
//   in_data      host word
//   in_last      final word of the transfer
//   out_valid    bank write request valid
//   out_ready    GLB accepts the request
//   out_tile     GLB tile index
//   out_addr     tile-local byte address, 8-byte aligned
//   out_data     packed bank word
//   out_strb     byte strobes (8'h0F low half, 8'hF0 high half)
//   busy         a transfer is in progress
//   err_unalign  one-cycle pulse when in_start carries a non word-aligned address
// -----------------------------------------------------------------------------
module glb_axi_wr_packer #(
    parameter int CGRA_WIDTH        = 32,
    parameter int GLB_TILE_MEM_SIZE = 256,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int BANK_DATA_WIDTH   = 64,
    localparam int NUM_GLB_TILES    = CGRA_WIDTH / 2,
    localparam int TILE_SEL_W       = $clog2(NUM_GLB_TILES),
    localparam int TILE_OFS_W       = $clog2(GLB_TILE_MEM_SIZE) + 10,
    localparam int GLB_ADDR_WIDTH   = TILE_OFS_W + TILE_SEL_W,
    localparam int STRB_W           = BANK_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_start,
    input  logic [GLB_ADDR_WIDTH-1:0]  in_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AXI_DATA_WIDTH-1:0]  in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TILE_SEL_W-1:0]      out_tile,
    output logic [TILE_OFS_W-1:0]      out_addr,
    output logic [BANK_DATA_WIDTH-1:0] out_data,
    output logic [STRB_W-1:0]          out_strb,
    output logic                       busy,
    output logic                       err_unalign
);

    localparam int HALF_STRB_W = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]                 state;
    logic [GLB_ADDR_WIDTH-1:0]  cur_addr;
    logic                       ptr;        // half of the bank word the next host word fills
    logic [BANK_DATA_WIDTH-1:0] acc_data;
    logic [STRB_W-1:0]          acc_strb;

    logic                       accept;
    logic                       emit;
    logic [BANK_DATA_WIDTH-1:0] next_data;
    logic [STRB_W-1:0]          next_strb;
    logic [GLB_ADDR_WIDTH-1:0]  bank_addr;

    // A new word may enter only when the output slot is free or is being
    // emptied in this same cycle, which keeps full throughput without a
    // second buffer entry.
    assign in_ready  = (state == FILL) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign emit      = accept && (ptr || in_last);
    assign busy      = (state != IDLE);
    assign bank_addr = {cur_addr[GLB_ADDR_WIDTH-1:3], 3'b000};

    // Accumulator contents as they would look with the current word merged in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        next_data = acc_data;
        next_strb = acc_strb;
        next_data[int'(ptr)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = in_data;
        next_strb[int'(ptr)*HALF_STRB_W +: HALF_STRB_W]       = '1;
    end

    // Control path and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // registers update together from values sampled at the clock edge.
            state       <= IDLE;
            cur_addr    <= '0;
            ptr         <= 1'b0;
            acc_data    <= '0;
            acc_strb    <= '0;
            err_unalign <= 1'b0;
        end else begin
            err_unalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_start) begin
                        if (in_addr[1:0] == 2'b00) begin
                            cur_addr <= in_addr;
                            ptr      <= in_addr[2];
                            acc_data <= '0;
                            acc_strb <= '0;
                            state    <= FILL;
                        end else begin
                            err_unalign <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        ptr <= ~ptr;
                        if (emit) begin
                            acc_data <= '0;
                            acc_strb <= '0;
                            // The tile index rides on the upper address bits, so
                            // a plain wrapping increment also crosses tiles.
                            cur_addr <= cur_addr + GLB_ADDR_WIDTH'(8);
                            if (in_last) begin
                                state <= DRAIN;
                            end
                        end else begin
                            acc_data <= next_data;
                            acc_strb <= next_strb;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output request register; contents hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tile  <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            out_strb  <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_tile  <= bank_addr[GLB_ADDR_WIDTH-1:TILE_OFS_W];
            out_addr  <= bank_addr[TILE_OFS_W-1:0];
            out_data  <= next_data;
            out_strb  <= next_strb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_glb_axi_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_glb_axi_wr_packer
//
// Self-checking bench for glb_axi_wr_packer. A reference model turns each
// transfer (base address + word list) into the expected bank writes by
// grouping words by their 8-byte bank address; a monitor compares every
// accepted output request against that expectation queue.
// -----------------------------------------------------------------------------
module tb_glb_axi_wr_packer;

    typedef struct packed {
        logic [3:0]  tile;
        logic [17:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_start;
    logic [21:0] in_addr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tile;
    logic [17:0] out_addr;
    logic [63:0] out_data;
    logic [7:0]  out_strb;
    logic        busy;
    logic        err_unalign;

    int   n_assert;
    int   n_fail;
    bit   rand_ready;
    exp_t exp_q[$];
    logic [31:0] words [0:15];

    glb_axi_wr_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_start    (in_start),
        .in_addr     (in_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tile    (out_tile),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_strb    (out_strb),
        .busy        (busy),
        .err_unalign (err_unalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; optionally randomise backpressure.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference model: word i lives at byte base+4*i; words sharing an 8-byte
    // bank address form one bank write, bit 2 selecting the half.
    task automatic expect_xfer(input logic [21:0] base, input int n);
        exp_t        cur;
        bit          open;
        logic [21:0] a;
        logic [21:0] bank;
        open = 1'b0;
        cur  = '0;
        for (int i = 0; i < n; i++) begin
            a    = base + 22'(4 * i);
            bank = a & ~22'h7;
            if (!open || {cur.tile, cur.addr} != bank) begin
                if (open) exp_q.push_back(cur);
                cur      = '0;
                cur.tile = bank[21:18];
                cur.addr = bank[17:0];
                open     = 1'b1;
            end
            if (a[2]) begin
                cur.data[63:32] = words[i];
                cur.strb[7:4]   = 4'hF;
            end else begin
                cur.data[31:0]  = words[i];
                cur.strb[3:0]   = 4'hF;
            end
        end
        if (open) exp_q.push_back(cur);
    endtask

    task automatic do_start(input logic [21:0] base);
        in_start = 1'b1;
        in_addr  = base;
        tick();
        in_start = 1'b0;
        in_addr  = '0;
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        tick();
    endtask

    task automatic send_word(input logic [31:0] d, input bit last);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
            n++;
        end
        check("in_handshake_timeout", ok, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (!busy && !out_valid) ok = 1'b1;
            tick();
            n++;
        end
        check("drain_timeout", ok, 1'b1);
        check("expected_words_left", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic run_xfer(input logic [21:0] base, input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
        expect_xfer(base, n);
        do_start(base);
        for (int i = 0; i < n; i++) send_word(words[i], i == n - 1);
        wait_idle();
    endtask

    // Output monitor: every request accepted by the GLB must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_output", out_valid, 1'b0);
            end else begin
                check("out_tile", out_tile, exp_q[0].tile);
                check("out_addr", out_addr, exp_q[0].addr);
                check("out_data", out_data, exp_q[0].data);
                check("out_strb", out_strb, exp_q[0].strb);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        in_start   = 1'b0;
        in_addr    = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // Reset state.
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_err", err_unalign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // in_valid while idle is ignored.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 1'b0);
            check("idle_out_valid", out_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0;

        // Test 1: base 0, four words; a mid-transfer in_start is ignored.
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        words[3] = 32'hDDDD_0004;
        expect_xfer(22'h000000, 4);
        do_start(22'h000000);
        send_word(words[0], 1'b0);
        in_start = 1'b1;
        in_addr  = 22'h002000;
        tick();
        in_start = 1'b0;
        in_addr  = '0;
        send_word(words[1], 1'b0);
        @(negedge clk);
        check("t1_latency_valid", out_valid, 1'b1);
        check("t1_latency_data", out_data, 64'hBBBB_0002_AAAA_0001);
        tick();
        send_word(words[2], 1'b0);
        send_word(words[3], 1'b1);
        wait_idle();
        check("t1_busy_done", busy, 1'b0);

        // Test 2: base 4, odd count -> first word high half only.
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        expect_xfer(22'h000004, 3);
        check("t2_model_first_strb", exp_q[0].strb, 8'hF0);
        do_start(22'h000004);
        for (int i = 0; i < 3; i++) send_word(words[i], i == 2);
        wait_idle();

        // Test 3: tile boundary crossing.
        run_xfer(22'h03FFF8, 4);
        // Address space wrap at the top of the last tile.
        run_xfer(22'h3FFFF8, 4);
        // Odd count from an aligned base -> last word low half only.
        run_xfer(22'h000100, 3);

        // Test 4: hold out_ready low for 5 cycles after the first emit.
        out_ready = 1'b0;
        words[0] = 32'h0A0A_0A0A;
        words[1] = 32'h0B0B_0B0B;
        words[2] = 32'h0C0C_0C0C;
        words[3] = 32'h0D0D_0D0D;
        expect_xfer(22'h000200, 4);
        do_start(22'h000200);
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        in_valid = 1'b1;
        in_data  = words[2];
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_valid", out_valid, 1'b1);
            check("t4_stall_in_ready", in_ready, 1'b0);
            check("t4_stall_data", out_data, 64'h0B0B_0B0B_0A0A_0A0A);
            check("t4_stall_addr", out_addr, 18'h00200);
            check("t4_stall_strb", out_strb, 8'hFF);
            tick();
        end
        out_ready = 1'b1;
        send_word(words[2], 1'b0);
        send_word(words[3], 1'b1);
        wait_idle();

        // Test 5: unaligned start.
        in_start = 1'b1;
        in_addr  = 22'h000002;
        tick();
        in_start = 1'b0;
        in_addr  = '0;
        @(negedge clk);
        check("t5_err_pulse", err_unalign, 1'b1);
        check("t5_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        check("t5_err_clear", err_unalign, 1'b0);
        check("t5_no_output", out_valid, 1'b0);
        check("t5_busy_after", busy, 1'b0);
        tick();

        // Test 6: reset after one of two words; partial word is discarded.
        do_start(22'h000000);
        send_word(32'h5555_5555, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_data", out_data, 64'h0);
        check("t6_rst_strb", out_strb, 8'h0);
        check("t6_rst_addr", {out_tile, out_addr}, 22'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_xfer(22'h000010, 2);

        // Randomised transfers with random backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            run_xfer(22'($urandom) & ~22'h3, int'($urandom_range(1, 9)));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
